// File: rtl/score_bcd_display.sv
// -----------------------------------------------------------------------------
// score_bcd_display
// Shows the game's high score in decimal on four active-low 7-segment digits.
// Binary-to-BCD conversion is sequential (shift-add-3, one bit per clock), and
// a new higher record flashes the display for FLASH_COUNT half-periods.
//
// Ports:
//   CLOCK_50    in   system clock
//   reset       in   asynchronous, active-high reset
//   toggle      in   block enable; 0 freezes every register
//   score       in   SCORE_W-bit high score from the game
//   blank_lz    in   1 = suppress leading zeros on HEX3..HEX1 (sampled in DONE)
//   HEX0..HEX3  out  ones..thousands digit, active-low, bit0=a .. bit6=g
//   busy        out  conversion in progress
//   new_record  out  record flash running
// -----------------------------------------------------------------------------
module score_bcd_display #(
    parameter int unsigned SCORE_W     = 11,
    parameter int unsigned FLASH_DIV   = 25000000,
    parameter int unsigned FLASH_COUNT = 6
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               toggle,
    input  logic [SCORE_W-1:0] score,
    input  logic               blank_lz,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX3,
    output logic               busy,
    output logic               new_record
);

    localparam int unsigned BCD_W  = 16;
    localparam int unsigned SR_W   = BCD_W + SCORE_W;
    localparam int unsigned CNT_W  = $clog2(SCORE_W + 1);
    localparam int unsigned DIV_W  = $clog2(FLASH_DIV + 1);
    localparam int unsigned HALF_W = $clog2(FLASH_COUNT + 1);

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Digit to active-low segment image.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   shadow_q, shadow_d;
    logic [SCORE_W-1:0]   disp_q, disp_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 rec_q, rec_d;
    logic                 phase_q, phase_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [HALF_W-1:0]    half_q, half_d;
    logic [3:0][6:0]      img_q, img_d;
    logic [3:0][6:0]      hex_q, hex_d;

    logic [SR_W-1:0]      sr_adj;
    logic [3:0][3:0]      dig;
    logic [3:0][6:0]      img_new;
    logic                 lz1, lz2, lz3;
    logic                 start_flash;

    // Add-3 correction on every BCD nibble that is 5 or more.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < 4; i++) begin
            if (sr_q[SCORE_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[SCORE_W + 4*i +: 4] = sr_q[SCORE_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Digit images from the finished BCD value, with optional leading-zero blanking.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dig[i] = sr_q[SCORE_W + 4*i +: 4];
        end
        lz3 = (dig[3] == 4'd0);
        lz2 = lz3 && (dig[2] == 4'd0);
        lz1 = lz2 && (dig[1] == 4'd0);
        img_new[0] = seg7(dig[0]);
        img_new[1] = (blank_lz && lz1) ? SEG_BLANK : seg7(dig[1]);
        img_new[2] = (blank_lz && lz2) ? SEG_BLANK : seg7(dig[2]);
        img_new[3] = (blank_lz && lz3) ? SEG_BLANK : seg7(dig[3]);
    end

    // Next-state logic: conversion FSM, record detection and flash timing.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        disp_d      = disp_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        rec_d       = rec_q;
        phase_d     = phase_q;
        div_d       = div_q;
        half_d      = half_q;
        img_d       = img_q;
        start_flash = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (score != shadow_q) begin
                    shadow_d = score;
                    sr_d     = {BCD_W'(0), score};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d  = sr_adj << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SCORE_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                img_d       = img_new;
                busy_d      = 1'b0;
                disp_d      = shadow_q;
                start_flash = (shadow_q > disp_q);
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new record restarts the flash; otherwise a running flash keeps counting.
        if (start_flash) begin
            rec_d   = 1'b1;
            div_d   = '0;
            half_d  = '0;
            phase_d = 1'b0;
        end else if (rec_q) begin
            if (div_q == DIV_W'(FLASH_DIV - 1)) begin
                div_d = '0;
                if (half_q == HALF_W'(FLASH_COUNT - 1)) begin
                    rec_d   = 1'b0;
                    phase_d = 1'b0;
                    half_d  = '0;
                end else begin
                    half_d  = half_q + HALF_W'(1);
                    phase_d = ~phase_q;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        hex_d = phase_d ? {4{SEG_BLANK}} : img_d;
    end

    // State registers; toggle low holds everything.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            disp_q   <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rec_q    <= 1'b0;
            phase_q  <= 1'b0;
            div_q    <= '0;
            half_q   <= '0;
            img_q    <= {4{SEG_ZERO}};
            hex_q    <= {4{SEG_ZERO}};
        end else if (toggle) begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            rec_q    <= rec_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            half_q   <= half_d;
            img_q    <= img_d;
            hex_q    <= hex_d;
        end
    end

    assign HEX0       = hex_q[0];
    assign HEX1       = hex_q[1];
    assign HEX2       = hex_q[2];
    assign HEX3       = hex_q[3];
    assign busy       = busy_q;
    assign new_record = rec_q;

endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
- Downstream stage of the timing game. Consumes the game's 11-bit high-score output and shows it in decimal on four 7-segment digits (HEX3..HEX0), active-low.
- Converts binary to BCD sequentially: shift-add-3, one bit per clock.
- Flashes the display when a new, higher record arrives.
- Shares the game's `toggle` enable, so it freezes whenever the game is deselected.

Parameters:
- SCORE_W, 11, width of the score input (the maximum displayed value is 2047, so four digits suffice).
- FLASH_DIV, 25000000, clock cycles per flash half-period (0.5 s at 50 MHz).
- FLASH_COUNT, 6, number of flash half-periods after a new record (must be even).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; the only clock.
- reset  in  1  asynchronous, active-high reset.
- toggle  in  1  block enable; when 0, every register holds its value.
- score  in  SCORE_W  high score from the game; may change on any cycle.
- blank_lz  in  1  1 = suppress leading zeros on HEX3..HEX1; sampled in DONE.
- HEX0  out  7  ones digit, active-low, bit0=a .. bit6=g.
- HEX1  out  7  tens digit.
- HEX2  out  7  hundreds digit.
- HEX3  out  7  thousands digit.
- busy  out  1  high while a conversion is in progress.
- new_record  out  1  high while the record flash is running.

Behaviour:
- All outputs are registered. The reset (asynchronous) values are:
  - HEX0..HEX3 = 7'b1000000 (shows "0000").
  - busy = 0, new_record = 0.
  - Shadow value = 0, displayed value = 0.
  - State = IDLE, flash counters = 0.
- Segment codes for digits 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Blank = 1111111.
- toggle = 0 freezes the FSM, the shift counter and the flash counters. Outputs hold their values.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on edge k, if score != shadow, capture score into shadow and into the shift register, clear the BCD accumulator, set busy = 1, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each edge, first add 3 to any BCD nibble >= 5, then shift the {BCD, binary} register left by 1. Exactly SCORE_W edges (k+1..k+SCORE_W), then go to DONE.
  - DONE (edge k+SCORE_W+1, i.e. k+12 by default):
    - Load the HEX registers from the four nibbles, applying blank_lz.
    - Set busy = 0 and return to IDLE.
- Latency: with the default width, a score change sampled at edge k reaches HEX at edge k+12. busy is high from after edge k until edge k+12.
- Score changes during SHIFT or DONE are ignored. IDLE re-compares on the next edge, so the final score value is always displayed eventually, with no lost updates.
- Leading-zero suppression (blank_lz = 1):
  - HEX3 is blank if the thousands digit is 0.
  - HEX2 is blank if it and all higher digits are 0; HEX1 likewise.
  - HEX0 always shows its digit.
- Record detection (in DONE): if the converted value > displayed value, set new_record = 1, clear the flash counters, and start flashing. Then update the displayed value unconditionally. A lower or equal value is shown without starting a flash.
- Flash:
  - While new_record = 1, a divider counts 0..FLASH_DIV-1. At wrap it toggles a blank phase and increments the half-period count.
  - Blank phase = 1 forces HEX0..HEX3 to 1111111; phase = 0 shows the digit image.
  - After FLASH_COUNT half-periods: new_record = 0, phase = 0, digits shown steadily.
  - A higher record completing mid-flash restarts the flash from count 0.
- Reset asserted in any state, including mid-conversion or mid-flash, immediately applies the reset values.
- Wrap/overflow: the BCD nibbles never exceed 9 for inputs <= 2047. Inputs wider than SCORE_W are not supported.

Test Plan:
- Reset: assert reset mid-SHIFT with score = 2047 -> HEX0..HEX3 = 1000000, busy = 0, new_record = 0 immediately (asynchronously).
- Conversion and latency: score 0 -> 1234 at edge k, blank_lz = 0 -> busy high for edges k..k+11; at edge k+12 HEX3..HEX0 = 1111001, 0100100, 0110000, 0011001; new_record = 1.
- Flash (FLASH_DIV = 4, FLASH_COUNT = 6): after 1234 -> HEX blank for cycles 4..7, 12..15 and 20..23 after DONE; new_record drops at cycle 24; then 1234 shows steadily. Applying 1234 -> 1000 afterwards updates the display with no flash.
- Leading zeros: blank_lz = 1, score = 7 -> HEX3..HEX1 = 1111111, HEX0 = 1111000. Score = 0 -> HEX0 = 1000000, others blank. Max value 2047 -> 0100100, 1000000, 0011001, 1111000.
- Mid-conversion change: score 5 at edge k, changed to 9 at edge k+3 -> 5 displayed at k+12; a second conversion starts at k+13; 9 displayed at k+25, restarting the flash.
- Freeze: toggle = 0 for 10 cycles during SHIFT -> busy stays 1 and the HEX registers are unchanged; completion is delayed by exactly 10 cycles.
